// File: rtl/i2s_pkg.sv
// Shared constants, slot counter type and NCO increment helper for the I2S transmitter.
package i2s_pkg;

  localparam int unsigned SLOT_BITS   = 32'd32;
  localparam int unsigned FRAME_SLOTS = 32'd64;

  typedef logic [5:0] slot_t;

  // Bit clock runs at 64*fs; the NCO ticks twice per bit clock period.
  function automatic logic [31:0] nco_inc(input logic [31:0] rate);
    return {rate[24:0], 7'd0};
  endfunction

endpackage

// File: rtl/i2s_nco.sv
// Fractional NCO: adds INC each clock and emits a tick whenever the accumulator wraps past CLK_RATE.
module i2s_nco #(
  parameter logic [31:0] CLK_RATE = 32'd57272700,
  parameter logic [31:0] INC      = 32'd6144000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  logic [31:0] r_acc;
  logic [32:0] w_sum;
  logic        w_tick;

  // Next accumulator value and wrap detection.
  always_comb begin
    w_sum  = {1'b0, r_acc} + {1'b0, INC};
    w_tick = (w_sum >= {1'b0, CLK_RATE});
  end

  // Accumulator register; the residue is kept so the long-term rate is exact.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc <= 32'd0;
    end else if (w_tick) begin
      r_acc <= 32'(w_sum - {1'b0, CLK_RATE});
    end else begin
      r_acc <= w_sum[31:0];
    end
  end

  assign o_tick = w_tick;

  if (INC >= CLK_RATE) begin : g_inc_check
    $error("i2s_nco: INC must be below CLK_RATE");
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S stereo serialiser with NCO-derived bit/word clocks, double-buffered samples and underrun reporting.
module i2s_audio_tx
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 32'd57272700,
  parameter int unsigned AUDIO_RATE = 32'd48000,
  parameter int unsigned AUDIO_DW   = 32'd16,
  parameter int unsigned SIGNED_IN  = 32'd1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AUDIO_DW-1:0] left_in,
  input  logic [AUDIO_DW-1:0] right_in,
  input  logic                sample_we,
  input  logic                mute,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data,
  output logic                sample_ack,
  output logic                underrun
);

  localparam logic [31:0] INC = nco_inc(32'(AUDIO_RATE));
  // Offset-binary input becomes two's complement by flipping the MSB on load.
  localparam logic [AUDIO_DW-1:0] MSB_FLIP =
    (SIGNED_IN != 32'd0) ? {AUDIO_DW{1'b0}} : {1'b1, {(AUDIO_DW-1){1'b0}}};

  logic                r_bck, r_lrck, r_data, r_ack, r_underrun, r_fresh;
  slot_t               r_n;
  logic [AUDIO_DW-1:0] r_pend_l, r_pend_r, r_act_l, r_act_r;

  logic                w_tick, w_fall, w_frame_start, w_bit;
  slot_t               w_n_next;
  logic [4:0]          w_k;
  logic [AUDIO_DW-1:0] w_word, w_shift;

  i2s_nco #(
    .CLK_RATE (32'(CLK_RATE)),
    .INC      (INC)
  ) u_nco (
    .i_clk   (clk),
    .i_reset (reset),
    .o_tick  (w_tick)
  );

  // Slot sequencing and selection of the next serial bit.
  always_comb begin
    w_fall        = w_tick & r_bck;
    w_n_next      = (r_n == slot_t'(FRAME_SLOTS - 32'd1)) ? 6'd0 : r_n + 6'd1;
    w_frame_start = w_fall & (w_n_next == 6'd0);
    w_k           = w_n_next[4:0];
    if (w_n_next[5]) begin
      w_word = r_act_r;
    end else begin
      w_word = r_act_l;
    end
    w_shift = w_word << (w_k - 5'd1);
    // Slot 0 of each half is the I2S delay bit; slots past the sample width pad with 0.
    if ((w_k != 5'd0) && ({27'd0, w_k} <= AUDIO_DW) && !mute) begin
      w_bit = w_shift[AUDIO_DW-1];
    end else begin
      w_bit = 1'b0;
    end
  end

  // Output, slot and sample buffer registers; everything visible moves on the bck falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bck      <= 1'b0;
      r_lrck     <= 1'b0;
      r_data     <= 1'b0;
      r_ack      <= 1'b0;
      r_underrun <= 1'b0;
      r_fresh    <= 1'b0;
      r_n        <= slot_t'(FRAME_SLOTS - 32'd1);
      r_pend_l   <= {AUDIO_DW{1'b0}};
      r_pend_r   <= {AUDIO_DW{1'b0}};
      r_act_l    <= {AUDIO_DW{1'b0}};
      r_act_r    <= {AUDIO_DW{1'b0}};
    end else begin
      r_ack      <= w_frame_start;
      r_underrun <= w_frame_start & ~r_fresh;
      if (w_tick) begin
        r_bck <= ~r_bck;
      end
      if (w_fall) begin
        r_n    <= w_n_next;
        r_lrck <= w_n_next[5];
        r_data <= w_bit;
      end
      // Active always takes the old pending value, so a same-cycle write waits for the next frame.
      if (w_frame_start) begin
        r_act_l <= r_pend_l ^ MSB_FLIP;
        r_act_r <= r_pend_r ^ MSB_FLIP;
      end
      if (sample_we) begin
        r_pend_l <= left_in;
        r_pend_r <= right_in;
        r_fresh  <= 1'b1;
      end else if (w_frame_start) begin
        r_fresh <= 1'b0;
      end
    end
  end

  assign i2s_bck    = r_bck;
  assign i2s_lrck   = r_lrck;
  assign i2s_data   = r_data;
  assign sample_ack = r_ack;
  assign underrun   = r_underrun;

  if ((AUDIO_DW < 32'd8) || (AUDIO_DW > 32'd24) || (AUDIO_DW >= SLOT_BITS)) begin : g_dw_check
    $error("i2s_audio_tx: AUDIO_DW must be within 8..24");
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Randomised bench: three transmitters (fast signed, fast unsigned, real clock rate) checked every cycle
// against an arithmetic model of tick timing, frame boundaries and the sample write history.
module tb_i2s_audio_tx;

  localparam longint INC_B  = 64'd6144000;
  localparam longint CLK_F  = 64'd12288000;
  localparam longint CLK_R  = 64'd57272700;

  typedef struct {
    longint      c;
    logic [15:0] l;
    logic [15:0] r;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, sample_we, mute;
  logic [15:0] left_in, right_in;
  logic        bck_s, lrck_s, data_s, ack_s, und_s;
  logic        bck_u, lrck_u, data_u, ack_u, und_u;
  logic        bck_r, lrck_r, data_r, ack_r, und_r;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  wr_t    wq[$];
  longint acks[$];
  bit     mute_hist [0:32767];

  always #5 clk = ~clk;

  i2s_audio_tx #(.CLK_RATE(32'd12288000), .AUDIO_RATE(32'd48000), .AUDIO_DW(32'd16), .SIGNED_IN(32'd1)) u_dut_s (
    .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in), .sample_we(sample_we), .mute(mute),
    .i2s_bck(bck_s), .i2s_lrck(lrck_s), .i2s_data(data_s), .sample_ack(ack_s), .underrun(und_s));

  i2s_audio_tx #(.CLK_RATE(32'd12288000), .AUDIO_RATE(32'd48000), .AUDIO_DW(32'd16), .SIGNED_IN(32'd0)) u_dut_u (
    .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in), .sample_we(sample_we), .mute(mute),
    .i2s_bck(bck_u), .i2s_lrck(lrck_u), .i2s_data(data_u), .sample_ack(ack_u), .underrun(und_u));

  i2s_audio_tx #(.CLK_RATE(32'd57272700), .AUDIO_RATE(32'd48000), .AUDIO_DW(32'd16), .SIGNED_IN(32'd1)) u_dut_r (
    .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in), .sample_we(sample_we), .mute(mute),
    .i2s_bck(bck_r), .i2s_lrck(lrck_r), .i2s_data(data_r), .sample_ack(ack_r), .underrun(und_r));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Ticks seen after c clocks, and the clock on which tick j happens (NCO starts from 0).
  function automatic longint tick_cnt(input longint c, input longint crate);
    return (c * INC_B) / crate;
  endfunction

  function automatic longint cyc_of_tick(input longint j, input longint crate);
    return (j * crate + INC_B - 1) / INC_B;
  endfunction

  // Word held in active for a frame starting at clock fs: the latest write strictly before fs.
  function automatic logic [31:0] act_word(input longint fs, input bit right, input bit unsig);
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < wq.size(); i++) begin
      if (wq[i].c < fs) w = right ? wq[i].r : wq[i].l;
    end
    if (unsig) w = w ^ 16'h8000;
    return {16'd0, w};
  endfunction

  function automatic bit wrote_in(input longint lo, input longint hi);
    for (int i = 0; i < wq.size(); i++) begin
      if (wq[i].c >= lo && wq[i].c < hi) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_inst(input string p, input longint crate, input logic bck, input logic lrck,
                            input logic data, input logic ack, input logic und, input bit unsig);
    longint t, f, n, fr, k, fs, fc, prev;
    logic   e_bck, e_lrck, e_data, e_ack, e_und;
    logic [31:0] w;
    e_lrck = 1'b0; e_data = 1'b0; e_ack = 1'b0; e_und = 1'b0;
    t     = tick_cnt(cyc, crate);
    e_bck = ((t % 2) == 1);
    f     = t / 2;
    if (f >= 1) begin
      n  = (f - 1) % 64;
      fr = (f - 1) / 64;
      k  = n % 32;
      fs = cyc_of_tick(2 + 128 * fr, crate);
      fc = cyc_of_tick(2 * f, crate);
      e_lrck = (n >= 32);
      if (k >= 1 && k <= 16 && !mute_hist[int'(fc)]) begin
        w = act_word(fs, e_lrck, unsig) >> (16 - k);
        e_data = w[0];
      end
      if (cyc == fs) begin
        e_ack = 1'b1;
        prev  = (fr == 0) ? 0 : cyc_of_tick(2 + 128 * (fr - 1), crate);
        e_und = !wrote_in(prev, fs);
      end
    end
    check_val({p, "_bck"},  {31'd0, bck},  {31'd0, e_bck});
    check_val({p, "_lrck"}, {31'd0, lrck}, {31'd0, e_lrck});
    check_val({p, "_data"}, {31'd0, data}, {31'd0, e_data});
    check_val({p, "_ack"},  {31'd0, ack},  {31'd0, e_ack});
    check_val({p, "_und"},  {31'd0, und},  {31'd0, e_und});
  endtask

  task automatic step(input bit we, input logic [15:0] l, input logic [15:0] r, input bit mu, input bit rst);
    wr_t e;
    sample_we = we; left_in = l; right_in = r; mute = mu; reset = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      cyc = 0;
      wq.delete();
      acks.delete();
    end else begin
      cyc++;
      mute_hist[int'(cyc)] = mu;
      if (we) begin
        e.c = cyc; e.l = l; e.r = r;
        wq.push_back(e);
      end
    end
    check_inst("sgn", CLK_F, bck_s, lrck_s, data_s, ack_s, und_s, 1'b0);
    check_inst("uns", CLK_F, bck_u, lrck_u, data_u, ack_u, und_u, 1'b1);
    check_inst("rate", CLK_R, bck_r, lrck_r, data_r, ack_r, und_r, 1'b0);
    if (ack_r) acks.push_back(cyc);
  endtask

  task automatic run(input int ncyc, input int pct, input bit mu);
    bit we;
    for (int i = 0; i < ncyc; i++) begin
      we = ($urandom_range(0, 99) < pct);
      step(we, 16'($urandom), 16'($urandom), mu, 1'b0);
    end
  endtask

  // Steps idle cycles until the next step lands on clock `target`.
  task automatic run_to(input longint target);
    while (cyc + 1 < target) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  // Next frame start (fast instances) strictly after clock c.
  function automatic longint next_fs(input longint c);
    if (c < 4) return 4;
    return 4 + 256 * ((c - 4) / 256 + 1);
  endfunction

  initial begin
    longint gap, t_end, exp_acks;
    logic [15:0] a_l, a_r;
    sample_we = 1'b0; mute = 1'b0; left_in = 16'h0000; right_in = 16'h0000; reset = 1'b1;

    repeat (3) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'h8001, 16'h7FFE, 1'b0, 1'b0);
    run(400, 0, 1'b0);

    run(256 * 5, 2, 1'b0);

    // Pending holds zero, then a write lands exactly on a frame start.
    run_to(next_fs(cyc) + 100);
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_to(next_fs(cyc));
    a_l = 16'($urandom); a_r = 16'($urandom);
    step(1'b1, a_l, a_r, 1'b0, 1'b0);
    run(256 * 2 + 8, 0, 1'b0);

    run(256 * 3, 0, 1'b0);
    run(256 * 2, 3, 1'b1);
    run(64, 3, 1'b0);

    // Reset in the middle of slot 20, then a long clean run for the real-rate timing.
    run_to(next_fs(cyc) + 81);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    run(14600, 2, 1'b0);

    t_end    = tick_cnt(cyc, CLK_R);
    exp_acks = (t_end >= 2) ? ((t_end - 2) / 128 + 1) : 0;
    check_val("rate_ack_count", 32'(acks.size()), 32'(exp_acks));
    if (acks.size() >= 13) begin
      gap = acks[12] - acks[0];
      check_val("rate_gap_within_1", {31'd0, ((gap * 48000 - 12 * CLK_R) <= 48000) &&
                                              ((12 * CLK_R - gap * 48000) <= 48000)}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
